// File: rtl/bridge_buffer_pp.sv
// Ping-pong bridge buffer: one bank fills with a tile while the other replays it NUM_PASSES times.
// Optional macro BRIDGE_BUF_STATS_EN adds a saturating 16-bit output stall counter (stall_cnt).
module bridge_buffer_pp #(
   parameter int WIDTH         = 16,
   parameter int CHUNK_SIZE    = 4,
   parameter int NUM_CORES     = 1,
   parameter int TOTAL_MODULES = 2,
   parameter int TOTAL_INPUT_W = 2,
   parameter int ROW_X         = 4,
   parameter int COL_X         = 4,
   parameter int TRANSPOSE     = 0,
   parameter int NUM_PASSES    = 1,
   localparam int SLICE_W      = WIDTH * CHUNK_SIZE * NUM_CORES,
   localparam int IN_W         = SLICE_W * TOTAL_MODULES,
   localparam int OUT_W        = SLICE_W * TOTAL_INPUT_W,
   localparam int PASS_W       = $clog2(NUM_PASSES + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IN_W-1:0]   in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_data,
   output logic              out_last,
   output logic [PASS_W-1:0] out_pass,
   output logic [1:0]        bank_full,
   output logic              done
`ifdef BRIDGE_BUF_STATS_EN
   ,
   output logic [15:0]       stall_cnt
`endif
);

   localparam int DEPTH   = ROW_X * COL_X;
   localparam int ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int INNER   = (TRANSPOSE != 0) ? ROW_X : COL_X;
   localparam int OUTER   = ((TRANSPOSE != 0) ? COL_X : ROW_X) / TOTAL_INPUT_W;
   localparam int INNER_W = (INNER > 1) ? $clog2(INNER) : 1;
   localparam int OUTER_W = (OUTER > 1) ? $clog2(OUTER) : 1;

   typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;

   logic [SLICE_W-1:0] mem [2][DEPTH];
   bank_state_t        bank_reg [2];
   bank_state_t        bank_next [2];

   logic               wr_sel_reg;
   logic               wr_sel_next;
   logic               ld_sel_reg;
   logic               rd_sel_reg;
   logic [ADDR_W-1:0]  wr_ptr_reg;
   logic [INNER_W-1:0] ld_inner_reg;
   logic [OUTER_W-1:0] ld_outer_reg;
   logic [PASS_W-1:0]  ld_pass_reg;

   logic               wr_fire;
   logic               wr_last;
   logic               ld_fire;
   logic               ld_pass_end;
   logic               ld_bank_end;
   logic               bank_release;
   logic [OUT_W-1:0]   ld_data;

   assign wr_fire      = in_valid && in_ready;
   assign wr_last      = (wr_ptr_reg == ADDR_W'(DEPTH - TOTAL_MODULES));
   assign ld_fire      = (!out_valid || out_ready) &&
                         ((bank_reg[ld_sel_reg] == FULL) || (bank_reg[ld_sel_reg] == DRAINING));
   assign ld_pass_end  = (ld_inner_reg == INNER_W'(INNER - 1)) && (ld_outer_reg == OUTER_W'(OUTER - 1));
   assign ld_bank_end  = ld_pass_end && (ld_pass_reg == PASS_W'(NUM_PASSES - 1));
   assign bank_release = out_valid && out_ready && out_last && (out_pass == PASS_W'(NUM_PASSES - 1));
   assign wr_sel_next  = (wr_fire && wr_last) ? ~wr_sel_reg : wr_sel_reg;

   for (genvar gi = 0; gi < 2; gi++) begin : g_status
      assign bank_full[gi] = (bank_reg[gi] == FULL) || (bank_reg[gi] == DRAINING);
   end

   // Load side (ld_sel) moves on as soon as the last beat enters the output register;
   // the bank itself is only released (rd_sel) once that beat is accepted.
   for (genvar gi = 0; gi < TOTAL_INPUT_W; gi++) begin : g_rd_lane
      logic [ADDR_W-1:0] rd_addr;
      if (TRANSPOSE == 0) begin : g_west
         assign rd_addr = ADDR_W'((int'(ld_outer_reg) * TOTAL_INPUT_W + gi) * COL_X + int'(ld_inner_reg));
      end else begin : g_north
         assign rd_addr = ADDR_W'(int'(ld_inner_reg) * COL_X + int'(ld_outer_reg) * TOTAL_INPUT_W + gi);
      end
      assign ld_data[gi*SLICE_W +: SLICE_W] = mem[ld_sel_reg][rd_addr];
   end

   always_comb begin
      for (int b = 0; b < 2; b++) begin
         bank_next[b] = bank_reg[b];
      end
      if (wr_fire) begin
         bank_next[wr_sel_reg] = wr_last ? FULL : FILLING;
      end
      if (ld_fire && (bank_reg[ld_sel_reg] == FULL)) begin
         bank_next[ld_sel_reg] = DRAINING;
      end
      if (bank_release) begin
         bank_next[rd_sel_reg] = EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_fire) begin
         for (int m = 0; m < TOTAL_MODULES; m++) begin
            mem[wr_sel_reg][wr_ptr_reg + ADDR_W'(m)] <= in_data[m*SLICE_W +: SLICE_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int b = 0; b < 2; b++) begin
            bank_reg[b] <= EMPTY;
         end
         wr_sel_reg   <= 1'b0;
         ld_sel_reg   <= 1'b0;
         rd_sel_reg   <= 1'b0;
         wr_ptr_reg   <= '0;
         ld_inner_reg <= '0;
         ld_outer_reg <= '0;
         ld_pass_reg  <= '0;
         in_ready     <= 1'b1;
         out_valid    <= 1'b0;
         out_data     <= '0;
         out_last     <= 1'b0;
         out_pass     <= '0;
         done         <= 1'b0;
      end else begin
         for (int b = 0; b < 2; b++) begin
            bank_reg[b] <= bank_next[b];
         end
         wr_sel_reg <= wr_sel_next;
         in_ready   <= (bank_next[wr_sel_next] == EMPTY) || (bank_next[wr_sel_next] == FILLING);
         done       <= bank_release;
         if (wr_fire) begin
            wr_ptr_reg <= wr_last ? '0 : wr_ptr_reg + ADDR_W'(TOTAL_MODULES);
         end
         if (bank_release) begin
            rd_sel_reg <= ~rd_sel_reg;
         end
         if (ld_fire) begin
            out_valid <= 1'b1;
            out_data  <= ld_data;
            out_last  <= ld_pass_end;
            out_pass  <= ld_pass_reg;
            if (ld_inner_reg == INNER_W'(INNER - 1)) begin
               ld_inner_reg <= '0;
               if (ld_outer_reg == OUTER_W'(OUTER - 1)) begin
                  ld_outer_reg <= '0;
                  if (ld_bank_end) begin
                     ld_pass_reg <= '0;
                     ld_sel_reg  <= ~ld_sel_reg;
                  end else begin
                     ld_pass_reg <= ld_pass_reg + PASS_W'(1);
                  end
               end else begin
                  ld_outer_reg <= ld_outer_reg + OUTER_W'(1);
               end
            end else begin
               ld_inner_reg <= ld_inner_reg + INNER_W'(1);
            end
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_pass  <= '0;
         end
      end
   end

`ifdef BRIDGE_BUF_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: doc/bridge_buffer_pp.md
Name: bridge_buffer_pp

Overview:
- Parametrised double-banked (ping-pong) bridge buffer between one matmul stage and the next, e.g. the linear-projection output feeding the Qn·KnT west or north port.
- Captures a full tile of slices from TOTAL_MODULES upstream modules and replays it NUM_PASSES times, TOTAL_INPUT_W slices per beat.
- Read order is row-group-major (west) or transposed column-group-major (north), selected by TRANSPOSE.
- One bank can fill while the other drains.

Parameters:
- WIDTH, 16, element width in bits.
- CHUNK_SIZE, 4, elements per core chunk.
- NUM_CORES, 1, cores per slice (NUM_CORES_A for west, NUM_CORES_B for north).
- TOTAL_MODULES, 2, upstream modules per input beat; must divide COL_X.
- TOTAL_INPUT_W, 2, slices per output beat; must divide ROW_X (TRANSPOSE=0) or COL_X (TRANSPOSE=1).
- ROW_X, 4, tile rows in slice units.
- COL_X, 4, tile columns in slice units.
- TRANSPOSE, 0, 0 = west order, 1 = north (transposed) order.
- NUM_PASSES, 1, full replays of a bank before release (>=1).
- Derived: SLICE_W = WIDTH*CHUNK_SIZE*NUM_CORES; IN_W = SLICE_W*TOTAL_MODULES; OUT_W = SLICE_W*TOTAL_INPUT_W; DEPTH = ROW_X*COL_X slices per bank.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  write bank can accept.
- in_data  in  IN_W  slice m at bits [m*SLICE_W +: SLICE_W].
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  OUT_W  slice j at bits [j*SLICE_W +: SLICE_W].
- out_last  out  1  final beat of the current pass.
- out_pass  out  $clog2(NUM_PASSES+1)  index of the current pass.
- bank_full  out  2  per-bank FULL/DRAINING status.
- done  out  1  one-cycle pulse when a bank is released.

Behaviour:
- Reset (rst_n low at a clk edge):
  - Both banks EMPTY; wr_sel = rd_sel = 0; all pointers 0.
  - in_ready=1, out_valid=0, out_last=0, out_data=0, out_pass=0, bank_full=0, done=0.
  - Reset mid-operation discards all stored data; no partial output follows.
- Storage: two banks of DEPTH x SLICE_W. Row-major address a = r*COL_X + c.
- Bank states: EMPTY -> FILLING (first accepted write) -> FULL (last write) -> DRAINING (first read) -> EMPTY (last beat of last pass accepted).
- Write side:
  - Accept when in_valid && in_ready.
  - Slice m goes to address wr_ptr+m of bank wr_sel; wr_ptr += TOTAL_MODULES.
  - After DEPTH/TOTAL_MODULES beats: bank -> FULL, wr_ptr=0, wr_sel toggles.
  - in_ready is registered, equal to (bank[wr_sel]==EMPTY or FILLING).
- Read side:
  - Output register loads when (!out_valid || out_ready) and the rd_sel bank is FULL/DRAINING with beats remaining.
  - First out_valid appears 1 cycle after that bank reaches FULL.
  - Sustains 1 beat/cycle with out_ready held high, no bubbles, including across pass boundaries.
  - out_data, out_valid and out_last stay stable while out_valid && !out_ready.
- Beat order, TRANSPOSE=0: beat holds rows r0..r0+TIW-1 at column c; c iterates fastest, then r0 += TIW.
- Beat order, TRANSPOSE=1: beat holds columns c0..c0+TIW-1 at row r; r iterates fastest, then c0 += TIW.
- Passes: DEPTH/TIW beats per pass. out_last is set on the final beat of each pass, and out_pass increments after it.
- Release: after the NUM_PASSES-th out_last handshake, the bank goes EMPTY, done pulses, rd_sel toggles and out_pass returns to 0.
- Simultaneous events:
  - Write completion on one bank and release of the other in the same cycle are both applied.
  - A released bank equal to wr_sel raises in_ready the next cycle.
  - If the other bank is already FULL at release, out_valid continues with no bubble.
- Back-pressure: when both banks are FULL/DRAINING, in_ready=0. in_valid while in_ready=0 has no effect.

Optional Feature:
- Macro: BRIDGE_BUF_STATS_EN.
- Defined: adds output stall_cnt (16 bits), reset to 0. It increments on every cycle with out_valid && !out_ready, saturates at 0xFFFF, and is cleared only by reset.
- Undefined: no port and no logic; functional behaviour is identical.

Test Plan:
- Defaults, TRANSPOSE=0: write 8 beats, slice value = address 0..15 -> 8 beats {4,0},{5,1},{6,2},{7,3},{12,8},{13,9},{14,10},{15,11}; out_last on the 8th beat; done pulses once.
- TRANSPOSE=1, same data -> {1,0},{5,4},{9,8},{13,12},{3,2},{7,6},{11,10},{15,14}.
- NUM_PASSES=3, out_ready=1 -> 24 contiguous beats; out_last at beats 8/16/24; out_pass 0,1,2; done after beat 24 only.
- Streaming: write bank 0 and bank 1 back-to-back while reading -> 16 output beats with no gap; in_ready=0 for exactly the cycles when both banks are occupied.
- Hold out_ready=0 for 5 cycles at beat 3 -> out_data stable, no loss or duplicate; with BRIDGE_BUF_STATS_EN, stall_cnt=5.
- Assert rst_n=0 for one cycle after 4 write beats and 2 read beats -> all outputs at reset values next cycle; a fresh 8-beat tile reads out correctly.
